cvs_io_conditioner: RTL and testbench

//  Parametrised successor to the board-level I/O check logic. Takes NUM_IN raw asynchronous

---
 rtl/cvs_io_conditioner.sv | 110 +++++++++++
 tb/tb_cvs_io_conditioner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvs_io_conditioner.sv
// Pad-side I/O conditioner: per-channel synchroniser and debouncer, edge pulses,
// rising-edge event counter on channel 0, fixed check logic and a square-wave divider.
module cvs_io_conditioner #(
    parameter int unsigned NUM_IN          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned COUNT_WIDTH     = 16,
    parameter int unsigned DIV_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IN-1:0]      in,
    input  logic                   count_clr,
    input  logic [DIV_WIDTH-1:0]   div_half,
    output logic [NUM_IN-1:0]      in_db,
    output logic [NUM_IN-1:0]      rise_pulse,
    output logic [NUM_IN-1:0]      fall_pulse,
    output logic                   in0_and_in1_out,
    output logic                   in0_or_in1_out,
    output logic                   not_in2_out,
    output logic [COUNT_WIDTH-1:0] edge_count,
    output logic                   div_out
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0]      r_sync1;
    logic [NUM_IN-1:0]      r_sync2;
    logic [NUM_IN-1:0]      r_db;
    logic [NUM_IN-1:0]      r_db_d;
    logic [CNT_W-1:0]       r_cnt [NUM_IN];
    logic [NUM_IN-1:0]      w_db_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt [NUM_IN];
    logic [NUM_IN-1:0]      w_rise;
    logic [NUM_IN-1:0]      w_fall;
    logic [COUNT_WIDTH-1:0] r_ecnt;
    logic [DIV_WIDTH-1:0]   r_dcnt;
    logic [DIV_WIDTH-1:0]   r_hp;
    logic                   r_div;

    // Debounce: a differing level must persist DEBOUNCE_CYCLES samples; any agreement restarts.
    always_comb begin
        w_db_nxt = r_db;
        for (int i = 0; i < NUM_IN; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_db[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_db_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            for (int i = 0; i < NUM_IN; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            r_db    <= w_db_nxt;
            r_db_d  <= r_db;
            for (int i = 0; i < NUM_IN; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    assign w_rise = r_db & ~r_db_d;
    assign w_fall = ~r_db & r_db_d;

    // A clear coinciding with an event keeps the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ecnt <= '0;
        end else if (w_rise[0]) begin
            r_ecnt <= count_clr ? COUNT_WIDTH'(1) : r_ecnt + COUNT_WIDTH'(1);
        end else if (count_clr) begin
            r_ecnt <= '0;
        end
    end

    // Half-period is latched only at a toggle so setting changes never cut a half short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcnt <= '0;
            r_hp   <= '0;
            r_div  <= 1'b0;
        end else if (r_dcnt == r_hp) begin
            r_dcnt <= '0;
            r_hp   <= div_half;
            r_div  <= ~r_div;
        end else begin
            r_dcnt <= r_dcnt + DIV_WIDTH'(1);
        end
    end

    assign in_db           = r_db;
    assign rise_pulse      = w_rise;
    assign fall_pulse      = w_fall;
    assign in0_and_in1_out = r_db[0] & r_db[1];
    assign in0_or_in1_out  = r_db[0] | r_db[1];
    assign not_in2_out     = ~r_db[2];
    assign edge_count      = r_ecnt;
    assign div_out         = r_div;

endmodule

// File: tb/tb_cvs_io_conditioner.sv
// Scoreboard bench for cvs_io_conditioner: expected pulse events and divider toggles are queued
// with their cycle numbers and checked by a negedge monitor; static levels are checked inline.
module tb_cvs_io_conditioner;

    typedef struct {
        int         cyc;
        logic [4:0] rise;
        logic [4:0] fall;
    } ev_t;

    logic        clk;
    logic        rst;
    logic [4:0]  in1;
    logic        clr1;
    logic [7:0]  dh1;
    logic [4:0]  db1, rise1, fall1;
    logic        and1, or1, not1, div1;
    logic [15:0] ec1;

    logic [2:0]  in2;
    logic        clr2;
    logic [1:0]  dh2;
    logic [2:0]  db2, rise2, fall2;
    logic        and2, or2, not2, div2;
    logic [3:0]  ec2;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  evq[$];
    int   divq[$];
    logic div_mon = 1'b0;
    logic div_prev = 1'b0;

    cvs_io_conditioner u_dut (
        .clk(clk), .rst(rst), .in(in1), .count_clr(clr1), .div_half(dh1),
        .in_db(db1), .rise_pulse(rise1), .fall_pulse(fall1),
        .in0_and_in1_out(and1), .in0_or_in1_out(or1), .not_in2_out(not1),
        .edge_count(ec1), .div_out(div1)
    );

    // Small instance: single-cycle debounce and 4-bit counter so wrap is reachable quickly.
    cvs_io_conditioner #(
        .NUM_IN(3), .DEBOUNCE_CYCLES(1), .COUNT_WIDTH(4), .DIV_WIDTH(2)
    ) u_small (
        .clk(clk), .rst(rst), .in(in2), .count_clr(clr2), .div_half(dh2),
        .in_db(db2), .rise_pulse(rise2), .fall_pulse(fall2),
        .in0_and_in1_out(and2), .in0_or_in1_out(or2), .not_in2_out(not2),
        .edge_count(ec2), .div_out(div2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input logic [4:0] r, input logic [4:0] f);
        ev_t e;
        e.cyc = c; e.rise = r; e.fall = f;
        evq.push_back(e);
    endtask

    task automatic pulse_small(input int n);
        for (int i = 0; i < n; i++) begin
            in2[0] = 1'b1;
            repeat (4) @(negedge clk);
            in2[0] = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    // Monitor: every pulse and every watched divider toggle must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if ((|rise1) || (|fall1)) begin
                if (evq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got rise=%b fall=%b expected none (cycle %0d)",
                             rise1, fall1, cyc);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rise_pulse", 32'(rise1), 32'(e.rise));
                    chk("fall_pulse", 32'(fall1), 32'(e.fall));
                end
            end
            if (div_mon && (div1 !== div_prev)) begin
                if (divq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_div_toggle: got toggle expected none (cycle %0d)", cyc);
                end else begin
                    chk("div_toggle_cycle", 32'(cyc), 32'(divq.pop_front()));
                end
            end
        end
        div_prev = div1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int r;
        rst = 1'b1; in1 = '0; clr1 = 1'b0; dh1 = 8'd3;
        in2 = '0; clr2 = 1'b0; dh2 = 2'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_db", 32'(db1), 32'h0);
        chk("rst_not_in2", 32'(not1), 32'h1);
        chk("rst_div_out", 32'(div1), 32'h0);
        chk("rst_edge_count", 32'(ec1), 32'h0);
        chk("rst_and_or", 32'({and1, or1}), 32'h0);

        // Divider: period 8, then shortened mid-half, then maximum half-period
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        for (int i = 0; i < 6; i++) divq.push_back(r + 1 + 4 * i);
        div_mon = 1'b1;
        wait_cyc(r + 1);
        chk("post_rst_in_db", 32'(db1), 32'h0);
        chk("post_rst_not_in2", 32'(not1), 32'h1);
        wait_cyc(r + 23);
        dh1 = 8'd0;
        for (int i = 0; i < 6; i++) divq.push_back(r + 25 + i);
        wait_cyc(r + 30);
        dh1 = 8'd255;
        divq.push_back(r + 31);
        divq.push_back(r + 287);
        divq.push_back(r + 543);
        wait_cyc(r + 545);
        chk("div_queue_drained", 32'(divq.size()), 32'h0);
        div_mon = 1'b0;

        // Channel 0 rise: accepted 17 edges after sampling
        @(negedge clk);
        m = cyc;
        in1[0] = 1'b1;
        push_ev(m + 18, 5'b00001, 5'b00000);
        wait_cyc(m + 17);
        chk("in_db0_not_early", 32'(db1[0]), 32'h0);
        wait_cyc(m + 19);
        chk("in_db0_set", 32'(db1[0]), 32'h1);
        chk("edge_count_1", 32'(ec1), 32'h1);
        chk("or_out_1", 32'(or1), 32'h1);
        chk("and_out_0", 32'(and1), 32'h0);

        m = cyc;
        in1[1] = 1'b1;
        push_ev(m + 18, 5'b00010, 5'b00000);
        wait_cyc(m + 19);
        chk("and_out_1", 32'(and1), 32'h1);

        m = cyc;
        in1[1:0] = 2'b00;
        push_ev(m + 18, 5'b00000, 5'b00011);
        wait_cyc(m + 20);
        chk("edge_count_after_fall", 32'(ec1), 32'h1);
        chk("and_or_low", 32'({and1, or1}), 32'h0);

        // Glitch rejection on channel 1
        m = cyc;
        in1[1] = 1'b1;
        wait_cyc(m + 10);
        in1[1] = 1'b0;
        wait_cyc(m + 30);
        for (int b = 0; b < 4; b++) begin
            m = cyc;
            in1[1] = 1'b1;
            wait_cyc(m + 15);
            in1[1] = 1'b0;
            wait_cyc(m + 16);
        end
        repeat (20) @(negedge clk);
        chk("glitch_in_db1", 32'(db1[1]), 32'h0);

        // Exactly DEBOUNCE_CYCLES high is accepted
        m = cyc;
        in1[1] = 1'b1;
        push_ev(m + 18, 5'b00010, 5'b00000);
        wait_cyc(m + 16);
        in1[1] = 1'b0;
        push_ev(m + 34, 5'b00000, 5'b00010);
        wait_cyc(m + 36);
        chk("boundary_in_db1", 32'(db1[1]), 32'h0);

        // Async reset mid-operation
        m = cyc;
        in1[2] = 1'b1;
        push_ev(m + 18, 5'b00100, 5'b00000);
        wait_cyc(m + 20);
        chk("not_in2_low", 32'(not1), 32'h0);
        for (int i = 0; i < 600 && div1 !== 1'b1; i++) @(negedge clk);
        chk("div_high_before_reset", 32'(div1), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_in_db", 32'(db1), 32'h0);
        chk("async_not_in2", 32'(not1), 32'h1);
        chk("async_div_out", 32'(div1), 32'h0);
        chk("async_edge_count", 32'(ec1), 32'h0);
        chk("async_pulses", 32'({rise1, fall1}), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r = cyc;
        push_ev(r + 18, 5'b00100, 5'b00000);
        divq.push_back(r + 1);
        divq.push_back(r + 257);
        div_mon = 1'b1;
        wait_cyc(r + 260);
        chk("resume_div_drained", 32'(divq.size()), 32'h0);
        chk("resume_not_in2", 32'(not1), 32'h0);
        div_mon = 1'b0;

        // Counter wrap and clear interaction on the small instance
        pulse_small(15);
        chk("small_count_15", 32'(ec2), 32'hF);
        pulse_small(1);
        chk("small_count_wrap", 32'(ec2), 32'h0);
        pulse_small(2);
        chk("small_count_2", 32'(ec2), 32'h2);
        @(negedge clk);
        m = cyc;
        in2[0] = 1'b1;
        wait_cyc(m + 3);
        chk("small_rise_visible", 32'(rise2[0]), 32'h1);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        chk("clr_with_rise", 32'(ec2), 32'h1);
        in2[0] = 1'b0;
        repeat (6) @(negedge clk);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        chk("clr_alone", 32'(ec2), 32'h0);

        repeat (5) @(negedge clk);
        chk("event_queue_drained", 32'(evq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
